// File: rtl/ic_data_ecc_pkg.sv
// Shared definitions for the I-cache data RAM SECDED code: widths, H-matrix
// columns, check-bit inversion mask, error classes and the encoder function.
package ic_data_ecc_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 11;
    localparam int ECC_W  = 8;

    // Check bits are stored inverted under this mask.
    // It sits outside the span of the address columns (bit 7 set).
    // As a result, all-zero and all-one RAM words never decode as clean.
    localparam logic [ECC_W-1:0] ECC_INV_MASK = 8'h81;

    // Data columns are distinct weight-3 vectors, so a single data error is
    // always odd and a double data error always even.
    // Exactly one column has bit 7 set, which keeps the all-ones word uncorrectable.
    localparam logic [ECC_W-1:0] DATA_COLS [DATA_W] = '{
        8'h07, 8'h0B, 8'h0D, 8'h0E, 8'h13, 8'h15, 8'h16, 8'h19,
        8'h1A, 8'h1C, 8'h23, 8'h25, 8'h26, 8'h29, 8'h2A, 8'h2C,
        8'h31, 8'h32, 8'h34, 8'h38, 8'h43, 8'h45, 8'h46, 8'h49,
        8'h4A, 8'h4C, 8'h51, 8'h52, 8'h54, 8'h58, 8'h61, 8'h83
    };

    // Address columns are distinct weight-2 vectors confined to bits 0..6.
    // A single wrong address bit therefore yields a recognisable even syndrome.
    localparam logic [ECC_W-1:0] ADDR_COLS [ADDR_W] = '{
        8'h03, 8'h05, 8'h06, 8'h09, 8'h0A, 8'h0C, 8'h11, 8'h12,
        8'h14, 8'h18, 8'h21
    };

    typedef enum logic [2:0] {
        ECC_OK,
        ECC_SB_DATA,
        ECC_SB_CHK,
        ECC_ADDR,
        ECC_DB
    } ecc_class_t;

    // Check bits for a data word stored at a given address.
    // This is the same function the write-side encoder uses.
    function automatic logic [ECC_W-1:0] ic_data_ecc_enc(
        input logic [DATA_W-1:0] data,
        input logic [ADDR_W-1:0] addr
    );
        logic [ECC_W-1:0] ecc;
        ecc = ECC_INV_MASK;
        for (int i = 0; i < DATA_W; i++) begin
            if (data[i]) ecc = ecc ^ DATA_COLS[i];
        end
        for (int j = 0; j < ADDR_W; j++) begin
            if (addr[j]) ecc = ecc ^ ADDR_COLS[j];
        end
        return ecc;
    endfunction

endpackage

// File: rtl/ic_data_ecc_checker_if.sv
// Read-word handshake between the data RAM and the checker, and between the
// checker and its consumer. The checker takes the slave view.
interface ic_data_ecc_checker_if;
    import ic_data_ecc_pkg::*;

    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic [ECC_W-1:0]  rd_ecc;
    logic [ADDR_W-1:0] rd_addr;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_sb_err;
    logic              out_db_err;
    logic              out_addr_err;

    modport slave (
        input  rd_valid, rd_data, rd_ecc, rd_addr, out_ready,
        output rd_ready, out_valid, out_data, out_sb_err, out_db_err, out_addr_err
    );

    modport master (
        output rd_valid, rd_data, rd_ecc, rd_addr, out_ready,
        input  rd_ready, out_valid, out_data, out_sb_err, out_db_err, out_addr_err
    );

endinterface

// File: rtl/ic_data_ecc_syndrome.sv
// Combinational SECDED decode: syndrome, error class and corrected data.
module ic_data_ecc_syndrome
    import ic_data_ecc_pkg::*;
(
    input  logic              ecc_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [ECC_W-1:0]  ecc_in,
    output logic [ECC_W-1:0]  syndrome,
    output logic [DATA_W-1:0] data_out,
    output logic              sb_err,
    output logic              db_err,
    output logic              addr_err
);

    ecc_class_t        ecc_class;
    logic [DATA_W-1:0] flip_mask;
    logic              addr_hit;

    // Form the syndrome and sort it into exactly one error class.
    always_comb begin
        syndrome  = ic_data_ecc_enc(data_in, addr_in) ^ ecc_in;
        flip_mask = '0;
        addr_hit  = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (syndrome == DATA_COLS[i]) flip_mask[i] = 1'b1;
        end
        for (int j = 0; j < ADDR_W; j++) begin
            if (syndrome == ADDR_COLS[j]) addr_hit = 1'b1;
        end
        if (syndrome == '0) begin
            ecc_class = ECC_OK;
        end else if (|flip_mask) begin
            ecc_class = ECC_SB_DATA;
        end else if ($onehot(syndrome)) begin
            ecc_class = ECC_SB_CHK;
        end else if (addr_hit || (^syndrome)) begin
            ecc_class = ECC_ADDR;
        end else begin
            ecc_class = ECC_DB;
        end
    end

    // Flip the failing data bit only for a correctable data error; bypass all when disabled.
    always_comb begin
        data_out = data_in;
        sb_err   = 1'b0;
        db_err   = 1'b0;
        addr_err = 1'b0;
        if (ecc_en) begin
            if (ecc_class == ECC_SB_DATA) data_out = data_in ^ flip_mask;
            sb_err   = (ecc_class == ECC_SB_DATA) || (ecc_class == ECC_SB_CHK);
            db_err   = (ecc_class == ECC_DB);
            addr_err = (ecc_class == ECC_ADDR);
        end
    end

endmodule

// File: rtl/ic_data_ecc_checker.sv
// I-cache data RAM read-side ECC checker.
// It has one registered stage with a valid/ready handshake.
// It keeps a sticky first-error capture and saturating error counters.
module ic_data_ecc_checker
    import ic_data_ecc_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_a,
    input  logic                 ecc_en,
    input  logic                 err_clr,
    ic_data_ecc_checker_if.slave bus,
    output logic                 err_valid,
    output logic [ADDR_W-1:0]    err_addr,
    output logic [ECC_W-1:0]     err_syndrome,
    output logic [CNT_W-1:0]     sb_cnt,
    output logic [CNT_W-1:0]     db_cnt,
    output logic [CNT_W-1:0]     addr_cnt
);

    logic [ECC_W-1:0]  syndrome;
    logic [DATA_W-1:0] corr_data;
    logic              dec_sb;
    logic              dec_db;
    logic              dec_addr;
    logic              accept;

    logic              out_valid_q,    out_valid_d;
    logic [DATA_W-1:0] out_data_q,     out_data_d;
    logic              out_sb_q,       out_sb_d;
    logic              out_db_q,       out_db_d;
    logic              out_addr_q,     out_addr_d;
    logic              err_valid_q,    err_valid_d;
    logic [ADDR_W-1:0] err_addr_q,     err_addr_d;
    logic [ECC_W-1:0]  err_syndrome_q, err_syndrome_d;
    logic [CNT_W-1:0]  sb_cnt_q,       sb_cnt_d;
    logic [CNT_W-1:0]  db_cnt_q,       db_cnt_d;
    logic [CNT_W-1:0]  addr_cnt_q,     addr_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

    ic_data_ecc_syndrome u_syndrome (
        .ecc_en   (ecc_en),
        .data_in  (bus.rd_data),
        .addr_in  (bus.rd_addr),
        .ecc_in   (bus.rd_ecc),
        .syndrome (syndrome),
        .data_out (corr_data),
        .sb_err   (dec_sb),
        .db_err   (dec_db),
        .addr_err (dec_addr)
    );

    assign bus.rd_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.rd_valid && bus.rd_ready;

    // Next-state for the output stage, error counters and first-error capture.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_sb_d       = out_sb_q;
        out_db_d       = out_db_q;
        out_addr_d     = out_addr_q;
        err_valid_d    = err_valid_q;
        err_addr_d     = err_addr_q;
        err_syndrome_d = err_syndrome_q;
        sb_cnt_d       = sb_cnt_q;
        db_cnt_d       = db_cnt_q;
        addr_cnt_d     = addr_cnt_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = corr_data;
            out_sb_d    = dec_sb;
            out_db_d    = dec_db;
            out_addr_d  = dec_addr;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (err_clr) begin
            err_valid_d = 1'b0;
            sb_cnt_d    = '0;
            db_cnt_d    = '0;
            addr_cnt_d  = '0;
        end else if (accept) begin
            if (dec_sb)   sb_cnt_d   = sat_inc(sb_cnt_q);
            if (dec_db)   db_cnt_d   = sat_inc(db_cnt_q);
            if (dec_addr) addr_cnt_d = sat_inc(addr_cnt_q);
            if ((dec_sb || dec_db || dec_addr) && !err_valid_q) begin
                err_valid_d    = 1'b1;
                err_addr_d     = bus.rd_addr;
                err_syndrome_d = syndrome;
            end
        end
    end

    // Register all state; a word held in the stage is dropped on reset.
    always_ff @(posedge clk) begin
        if (rst_a) begin
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_sb_q       <= 1'b0;
            out_db_q       <= 1'b0;
            out_addr_q     <= 1'b0;
            err_valid_q    <= 1'b0;
            err_addr_q     <= '0;
            err_syndrome_q <= '0;
            sb_cnt_q       <= '0;
            db_cnt_q       <= '0;
            addr_cnt_q     <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_sb_q       <= out_sb_d;
            out_db_q       <= out_db_d;
            out_addr_q     <= out_addr_d;
            err_valid_q    <= err_valid_d;
            err_addr_q     <= err_addr_d;
            err_syndrome_q <= err_syndrome_d;
            sb_cnt_q       <= sb_cnt_d;
            db_cnt_q       <= db_cnt_d;
            addr_cnt_q     <= addr_cnt_d;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_sb_err   = out_sb_q;
    assign bus.out_db_err   = out_db_q;
    assign bus.out_addr_err = out_addr_q;
    assign err_valid        = err_valid_q;
    assign err_addr         = err_addr_q;
    assign err_syndrome     = err_syndrome_q;
    assign sb_cnt           = sb_cnt_q;
    assign db_cnt           = db_cnt_q;
    assign addr_cnt         = addr_cnt_q;

endmodule

// File: tb/tb_ic_data_ecc_checker.sv
// Self-checking bench for ic_data_ecc_checker.
// The reference decodes by searching for the nearest codeword.
module tb_ic_data_ecc_checker;

    logic        clk = 1'b0;
    logic        rst_a;
    logic        ecc_en;
    logic        err_clr;
    logic        err_valid;
    logic [10:0] err_addr;
    logic [7:0]  err_syndrome;
    logic [7:0]  sb_cnt;
    logic [7:0]  db_cnt;
    logic [7:0]  addr_cnt;

    int checks = 0;
    int errors = 0;

    ic_data_ecc_checker_if bus_if ();

    ic_data_ecc_checker #(.CNT_W(8)) dut (
        .clk          (clk),
        .rst_a        (rst_a),
        .ecc_en       (ecc_en),
        .err_clr      (err_clr),
        .bus          (bus_if),
        .err_valid    (err_valid),
        .err_addr     (err_addr),
        .err_syndrome (err_syndrome),
        .sb_cnt       (sb_cnt),
        .db_cnt       (db_cnt),
        .addr_cnt     (addr_cnt)
    );

    always #5 clk = ~clk;

    // Codebook of the I-cache data ECC: column per data bit and per address bit, plus inversion mask.
    localparam logic [7:0] TB_DCOL [32] = '{
        8'h07, 8'h0B, 8'h0D, 8'h0E, 8'h13, 8'h15, 8'h16, 8'h19,
        8'h1A, 8'h1C, 8'h23, 8'h25, 8'h26, 8'h29, 8'h2A, 8'h2C,
        8'h31, 8'h32, 8'h34, 8'h38, 8'h43, 8'h45, 8'h46, 8'h49,
        8'h4A, 8'h4C, 8'h51, 8'h52, 8'h54, 8'h58, 8'h61, 8'h83
    };
    localparam logic [7:0] TB_ACOL [11] = '{
        8'h03, 8'h05, 8'h06, 8'h09, 8'h0A, 8'h0C, 8'h11, 8'h12, 8'h14, 8'h18, 8'h21
    };

    function automatic logic [7:0] tb_enc(input logic [31:0] d, input logic [10:0] a);
        logic [7:0] e;
        e = 8'h81;
        for (int i = 0; i < 32; i++) if (d[i]) e = e ^ TB_DCOL[i];
        for (int k = 0; k < 11; k++) if (a[k]) e = e ^ TB_ACOL[k];
        return e;
    endfunction

    // Reference decode by search.
    // A valid codeword one data flip or one check flip away is a correctable error.
    // A codeword one address flip away is an address error.
    // Any other odd syndrome is an address error; any other even one is uncorrectable.
    function automatic void classify(
        input  logic [31:0] d, input logic [10:0] a, input logic [7:0] e, input logic en,
        output logic [31:0] od, output logic sb, output logic db, output logic ad,
        output logic [7:0] syn
    );
        logic found;
        syn = tb_enc(d, a) ^ e;
        od = d; sb = 1'b0; db = 1'b0; ad = 1'b0; found = 1'b0;
        if (en && syn != 8'h00) begin
            for (int i = 0; i < 32; i++) begin
                if (!found && tb_enc(d ^ (32'h1 << i), a) == e) begin
                    od = d ^ (32'h1 << i); sb = 1'b1; found = 1'b1;
                end
            end
            for (int j = 0; j < 8; j++) begin
                if (!found && tb_enc(d, a) == (e ^ (8'h1 << j))) begin
                    sb = 1'b1; found = 1'b1;
                end
            end
            for (int k = 0; k < 11; k++) begin
                if (!found && tb_enc(d, a ^ (11'h1 << k)) == e) begin
                    ad = 1'b1; found = 1'b1;
                end
            end
            if (!found) begin
                if ($countones(syn) % 2 == 1) ad = 1'b1;
                else db = 1'b1;
            end
        end
    endfunction

    // Model state
    logic        m_ov = 1'b0;
    logic [31:0] m_od = '0;
    logic        m_sb = 1'b0, m_db = 1'b0, m_ad = 1'b0;
    logic        m_ev = 1'b0;
    logic [10:0] m_ea = '0;
    logic [7:0]  m_es = '0;
    logic [7:0]  m_sbc = '0, m_dbc = '0, m_adc = '0;

    function automatic logic [7:0] sat8(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'h01;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic [31:0] cd;
        logic        csb, cdb, cad, rdy, acc;
        logic [7:0]  csyn;
        if (rst_a) begin
            m_ov = 1'b0; m_od = '0; m_sb = 1'b0; m_db = 1'b0; m_ad = 1'b0;
            m_ev = 1'b0; m_ea = '0; m_es = '0; m_sbc = '0; m_dbc = '0; m_adc = '0;
        end else begin
            rdy = !m_ov || bus_if.out_ready;
            acc = bus_if.rd_valid && rdy;
            classify(bus_if.rd_data, bus_if.rd_addr, bus_if.rd_ecc, ecc_en, cd, csb, cdb, cad, csyn);
            if (err_clr) begin
                m_sbc = '0; m_dbc = '0; m_adc = '0; m_ev = 1'b0;
            end else if (acc) begin
                if (csb) m_sbc = sat8(m_sbc);
                if (cdb) m_dbc = sat8(m_dbc);
                if (cad) m_adc = sat8(m_adc);
                if ((csb || cdb || cad) && !m_ev) begin
                    m_ev = 1'b1; m_ea = bus_if.rd_addr; m_es = csyn;
                end
            end
            if (acc) begin
                m_ov = 1'b1; m_od = cd; m_sb = csb; m_db = cdb; m_ad = cad;
            end else if (bus_if.out_ready) begin
                m_ov = 1'b0;
            end
        end
    endtask

    task automatic check_output(input string tag);
        check({tag, ".rd_ready"}, 64'(bus_if.rd_ready), 64'(!m_ov || bus_if.out_ready));
        check({tag, ".out_valid"}, 64'(bus_if.out_valid), 64'(m_ov));
        if (m_ov) begin
            check({tag, ".out_data"}, 64'(bus_if.out_data), 64'(m_od));
            check({tag, ".flags"},
                  64'({bus_if.out_sb_err, bus_if.out_db_err, bus_if.out_addr_err}),
                  64'({m_sb, m_db, m_ad}));
        end
        check({tag, ".counters"}, 64'({sb_cnt, db_cnt, addr_cnt}), 64'({m_sbc, m_dbc, m_adc}));
        check({tag, ".err_valid"}, 64'(err_valid), 64'(m_ev));
        if (m_ev) check({tag, ".capture"}, 64'({err_addr, err_syndrome}), 64'({m_ea, m_es}));
    endtask

    task automatic cycle_check(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_output(tag);
    endtask

    task automatic apply_stimulus(
        input logic v, input logic [31:0] d, input logic [10:0] a, input logic [7:0] e,
        input logic en, input logic ordy, input logic clr
    );
        bus_if.rd_valid  = v;
        bus_if.rd_data   = d;
        bus_if.rd_addr   = a;
        bus_if.rd_ecc    = e;
        ecc_en           = en;
        bus_if.out_ready = ordy;
        err_clr          = clr;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".out_valid"}, 64'(bus_if.out_valid), 64'(0));
        check({tag, ".out_data"}, 64'(bus_if.out_data), 64'(0));
        check({tag, ".flags"}, 64'({bus_if.out_sb_err, bus_if.out_db_err, bus_if.out_addr_err}), 64'(0));
        check({tag, ".err"}, 64'({err_valid, err_addr, err_syndrome}), 64'(0));
        check({tag, ".counters"}, 64'({sb_cnt, db_cnt, addr_cnt}), 64'(0));
        check({tag, ".rd_ready"}, 64'(bus_if.rd_ready), 64'(1));
    endtask

    typedef struct {
        logic [31:0] wr_data;
        logic [10:0] wr_addr;
        logic [31:0] rd_data;
        logic [10:0] rd_addr;
        logic [7:0]  ecc_flip;
        logic        use_raw;
        logic [7:0]  raw_ecc;
        logic        en;
        logic [31:0] exp_data;
        logic        exp_sb;
        logic        exp_db;
        logic        exp_ad;
        string       name;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [31:0] d, wd;
        logic [10:0] a;
        logic [7:0]  e;
        logic [4:0]  b1, b2;
        int          kind;

        vecs[0] = '{32'h12345678, 11'h155, 32'h12345678, 11'h155, 8'h00, 1'b0, 8'h00, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, "clean"};
        vecs[1] = '{32'h12345678, 11'h155, 32'h12345658, 11'h155, 8'h00, 1'b0, 8'h00, 1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0, "bit5"};
        vecs[2] = '{32'h12345678, 11'h155, 32'h92345679, 11'h155, 8'h00, 1'b0, 8'h00, 1'b1, 32'h92345679, 1'b0, 1'b1, 1'b0, "bits0_31"};
        vecs[3] = '{32'h12345678, 11'h155, 32'h12345678, 11'h154, 8'h00, 1'b0, 8'h00, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1, "addr"};
        vecs[4] = '{32'h00000000, 11'h3A7, 32'h00000000, 11'h3A7, 8'h00, 1'b1, 8'h00, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, "zeros"};
        vecs[5] = '{32'hFFFFFFFF, 11'h7FF, 32'hFFFFFFFF, 11'h7FF, 8'h00, 1'b1, 8'hFF, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, "ones"};
        vecs[6] = '{32'h12345678, 11'h155, 32'h12345678, 11'h155, 8'h08, 1'b0, 8'h00, 1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0, "chk3"};
        vecs[7] = '{32'hCAFEBABE, 11'h2F0, 32'hCAFCBABE, 11'h2F0, 8'h00, 1'b0, 8'h00, 1'b1, 32'hCAFEBABE, 1'b1, 1'b0, 1'b0, "bit17"};
        vecs[8] = '{32'h12345678, 11'h155, 32'h12345658, 11'h155, 8'h00, 1'b0, 8'h00, 1'b0, 32'h12345658, 1'b0, 1'b0, 1'b0, "bypass"};

        // Power-on reset
        rst_a = 1'b1;
        apply_stimulus(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_a = 1'b0;

        // Table-driven single words, streamed back to back
        for (int i = 0; i < 9; i++) begin
            e = vecs[i].use_raw ? vecs[i].raw_ecc : (tb_enc(vecs[i].wr_data, vecs[i].wr_addr) ^ vecs[i].ecc_flip);
            apply_stimulus(1'b1, vecs[i].rd_data, vecs[i].rd_addr, e, vecs[i].en, 1'b1, 1'b0);
            cycle_check(vecs[i].name);
            check({vecs[i].name, ".tbl_data"}, 64'(bus_if.out_data), 64'(vecs[i].exp_data));
            check({vecs[i].name, ".tbl_flags"},
                  64'({bus_if.out_sb_err, bus_if.out_db_err, bus_if.out_addr_err}),
                  64'({vecs[i].exp_sb, vecs[i].exp_db, vecs[i].exp_ad}));
        end
        apply_stimulus(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
        cycle_check("drain");
        check("table.err_addr", 64'(err_addr), 64'(11'h155));
        check("table.err_syndrome", 64'(err_syndrome), 64'(8'h15));
        check("table.counts", 64'({sb_cnt, db_cnt, addr_cnt}), 64'({8'd3, 8'd3, 8'd1}));

        // Backpressure: one word is held for three cycles while the next waits
        d = 32'hA5A5A5A5;
        apply_stimulus(1'b1, d ^ 32'h20, 11'h0AA, tb_enc(d, 11'h0AA), 1'b1, 1'b0, 1'b0);
        cycle_check("bp_load");
        check("bp_load.sb_cnt", 64'(sb_cnt), 64'(8'd4));
        apply_stimulus(1'b1, 32'h0F0F0F0F, 11'h011, tb_enc(32'h0F0F0F0F, 11'h011), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle_check("bp_hold");
            check("bp_hold.rd_ready", 64'(bus_if.rd_ready), 64'(0));
            check("bp_hold.out_data", 64'(bus_if.out_data), 64'(32'hA5A5A5A5));
            check("bp_hold.sb_cnt", 64'(sb_cnt), 64'(8'd4));
        end
        bus_if.out_ready = 1'b1;
        cycle_check("bp_release");
        check("bp_release.out_data", 64'(bus_if.out_data), 64'(32'h0F0F0F0F));

        // Clear coinciding with a flagged accept
        d = 32'h00C0FFEE;
        apply_stimulus(1'b1, d ^ 32'h100, 11'h200, tb_enc(d, 11'h200), 1'b1, 1'b1, 1'b1);
        cycle_check("clr_hit");
        check("clr_hit.counts", 64'({sb_cnt, db_cnt, addr_cnt}), 64'(0));
        check("clr_hit.err_valid", 64'(err_valid), 64'(0));

        // Randomized traffic with random backpressure, bypass and clears
        for (int n = 0; n < 400; n++) begin
            wd = $urandom;
            d = wd;
            a = 11'($urandom_range(0, 2047));
            e = tb_enc(wd, a);
            kind = int'($urandom_range(0, 5));
            b1 = 5'($urandom_range(0, 31));
            b2 = b1 + 5'($urandom_range(1, 31));
            case (kind)
                1: d = d ^ (32'h1 << b1);
                2: e = e ^ (8'h1 << b1[2:0]);
                3: d = d ^ (32'h1 << b1) ^ (32'h1 << b2);
                4: a = a ^ (11'h1 << ($urandom_range(0, 10)));
                5: e = 8'($urandom);
                default: ;
            endcase
            apply_stimulus($urandom_range(0, 3) != 0, d, a, e, $urandom_range(0, 7) != 0,
                           $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
            cycle_check("random");
        end

        // Saturation: 300 correctable errors after a clear
        apply_stimulus(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b1);
        cycle_check("sat_clr");
        for (int n = 0; n < 300; n++) begin
            wd = $urandom;
            a = 11'($urandom_range(0, 2047));
            apply_stimulus(1'b1, wd ^ (32'h1 << ($urandom_range(0, 31))), a, tb_enc(wd, a), 1'b1, 1'b1, 1'b0);
            cycle_check("sat");
        end
        check("sat.sb_cnt", 64'(sb_cnt), 64'(8'hFF));

        // Reset while a word is held in the stage
        apply_stimulus(1'b1, 32'h12345678, 11'h155, tb_enc(32'h12345678, 11'h155), 1'b1, 1'b0, 1'b0);
        cycle_check("pre_rst");
        check("pre_rst.out_valid", 64'(bus_if.out_valid), 64'(1));
        bus_if.rd_valid = 1'b0;
        rst_a = 1'b1;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_reset_values("mid_rst");
        rst_a = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
